// File: rtl/imm_pkg.sv
// Shared immediate-packing types: extender op encodings, packer FSM states, beat layout.
// Latency: n/a (types only).
// Backpressure: n/a. Used by imm_pack, imm_classify and the immediate extender.
package imm_pkg;

   // Extender operation carried with every immediate beat.
   typedef enum logic [1:0] {
      EOP_SIGN     = 2'b00,   // sign-extend imm
      EOP_ZERO     = 2'b01,   // zero-extend imm
      EOP_UPPER    = 2'b10,   // imm << 16 (lui)
      EOP_SIGN_SH2 = 2'b11    // sign-extend imm, then << 2
   } eop_e;

   // Packer output stage state.
   typedef enum logic [1:0] {
      IDLE = 2'b00,   // output register empty
      ONE  = 2'b01,   // single beat (or low half of a split) held
      HI   = 2'b10    // upper beat held, low half parked in lo_q
   } state_e;

   // One output beat as held in the output register.
   typedef struct packed {
      eop_e        eop;
      logic [15:0] imm;
      logic        last;
   } beat_t;

endpackage

// File: rtl/imm_pack_if.sv
// Handshake bundle between a constant producer, imm_pack and the extender-side consumer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; master = environment, slave = packer.
interface imm_pack_if;
   logic        in_valid;    // in_value holds a constant
   logic        in_ready;    // packer accepts in_value this cycle
   logic [31:0] in_value;    // constant to pack
   logic        out_valid;   // out_* hold a beat
   logic        out_ready;   // consumer takes the beat this cycle
   logic [15:0] out_imm;     // immediate field
   logic [1:0]  out_eop;     // extender op
   logic        out_last;    // final beat of the current constant

   modport master (
      output in_valid, in_value, out_ready,
      input  in_ready, out_valid, out_imm, out_eop, out_last
   );

   modport slave (
      input  in_valid, in_value, out_ready,
      output in_ready, out_valid, out_imm, out_eop, out_last
   );
endinterface

// File: rtl/imm_classify.sv
// Decides whether a 32-bit constant fits one extender op and produces that op's imm field.
// Latency: combinational.
// Backpressure: none. Ports: value/allow_sh2 in; fits/eop/imm out (upper beat when !fits).
module imm_classify
   import imm_pkg::*;
(
   input  logic [31:0] value,
   input  logic        allow_sh2,
   output logic        fits,
   output eop_e        eop,
   output logic [15:0] imm
);

   always_comb begin
      fits = 1'b1;
      eop  = EOP_SIGN;
      imm  = value[15:0];
      if (value[31:15] == {17{value[15]}}) begin
         eop = EOP_SIGN;
         imm = value[15:0];
      end else if (value[31:16] == 16'h0000) begin
         eop = EOP_ZERO;
         imm = value[15:0];
      end else if (value[15:0] == 16'h0000) begin
         eop = EOP_UPPER;
         imm = value[31:16];
      end else if (allow_sh2 && (value[1:0] == 2'b00) &&
                   (value[31:17] == {15{value[17]}})) begin
         eop = EOP_SIGN_SH2;
         imm = value[17:2];
      end else begin
         // Does not fit: report the first beat of the lui + zero-extend pair.
         fits = 1'b0;
         eop  = EOP_UPPER;
         imm  = value[31:16];
      end
   end

endmodule

// File: rtl/imm_pack.sv
// Packs 32-bit constants into 1 or 2 {eop, imm16, last} beats for the immediate extender.
// Latency: 1 cycle accept-to-out_valid (registered output); 1 constant/cycle when single-beat.
// Backpressure: in_ready = IDLE || (ONE && out_ready); low in HI and during reset.
// Ports: clk, reset (sync, active-high), bus (imm_pack_if.slave). ALLOW_SHIFT2 enables eop 11.
// Optional: define IMM_PACK_STATS_EN to add stat_single/stat_split accepted-constant counters.
module imm_pack
   import imm_pkg::*;
#(
   parameter int ALLOW_SHIFT2 = 1
) (
   input  logic        clk,
   input  logic        reset,
   imm_pack_if.slave   bus
`ifdef IMM_PACK_STATS_EN
   ,
   output logic [31:0] stat_single,
   output logic [31:0] stat_split
`endif
);

   state_e      state_q, state_d;
   beat_t       beat_q, beat_d;
   logic [15:0] lo_q, lo_d;      // low half of a split constant, waiting behind the upper beat

   logic        accept;
   logic        cls_fits;
   eop_e        cls_eop;
   logic [15:0] cls_imm;

   imm_classify u_classify (
      .value     (bus.in_value),
      .allow_sh2 (ALLOW_SHIFT2 != 0),
      .fits      (cls_fits),
      .eop       (cls_eop),
      .imm       (cls_imm)
   );

   // Gated by reset so nothing is accepted on an edge that is about to clear the state.
   assign bus.in_ready = !reset &&
                         ((state_q == IDLE) || ((state_q == ONE) && bus.out_ready));
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: ;
         ONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         HI: begin
            if (bus.out_ready) begin
               state_d     = ONE;
               beat_d.eop  = EOP_ZERO;
               beat_d.imm  = lo_q;
               beat_d.last = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Acceptance only happens in IDLE or while ONE drains, so the new beat
      // simply overrides the drain result: no bubble between constants.
      if (accept) begin
         beat_d.eop  = cls_eop;
         beat_d.imm  = cls_imm;
         beat_d.last = cls_fits;
         lo_d        = bus.in_value[15:0];
         state_d     = cls_fits ? ONE : HI;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.out_valid = (state_q != IDLE);
   assign bus.out_imm   = beat_q.imm;
   assign bus.out_eop   = beat_q.eop;
   assign bus.out_last  = beat_q.last;

`ifdef IMM_PACK_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_single <= '0;
         stat_split  <= '0;
      end else if (accept) begin
         if (cls_fits) stat_single <= stat_single + 32'd1;
         else          stat_split  <= stat_split + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: directed packing cases on ALLOW_SHIFT2=1 and =0 instances,
// then randomized traffic on the ALLOW_SHIFT2=1 instance against a value-range model.
// Stats counters are checked when IMM_PACK_STATS_EN is defined.
module tb_imm_pack;

   logic clk;
   logic reset;

   imm_pack_if a ();   // ALLOW_SHIFT2 = 1
   imm_pack_if b ();   // ALLOW_SHIFT2 = 0

`ifdef IMM_PACK_STATS_EN
   logic [31:0] stat_single_a, stat_split_a, stat_single_b, stat_split_b;
`endif

   imm_pack #(.ALLOW_SHIFT2(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (a)
`ifdef IMM_PACK_STATS_EN
      ,
      .stat_single (stat_single_a),
      .stat_split  (stat_split_a)
`endif
   );

   imm_pack #(.ALLOW_SHIFT2(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
`ifdef IMM_PACK_STATS_EN
      ,
      .stat_single (stat_single_b),
      .stat_split  (stat_split_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // got = {out_valid, out_eop, out_imm, out_last}
   task automatic check_out(input string tag, input logic [19:0] got,
                            input logic [1:0] eop, input logic [15:0] imm, input logic last);
      check(tag, {12'h0, got}, {12'h0, 1'b1, eop, imm, last});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // ---------------- reference model: value ranges, not bit slices ----------------
   logic [18:0] exp_q[$];   // {eop, imm, last}

   function automatic void model_push(input logic [31:0] v, input bit allow);
      int          s;
      logic [15:0] hi, lo;
      s  = int'(v);
      hi = 16'(v / 32'd65536);
      lo = 16'(v % 32'd65536);
      if (s >= -32768 && s <= 32767)
         exp_q.push_back({2'b00, lo, 1'b1});
      else if (v < 32'd65536)
         exp_q.push_back({2'b01, lo, 1'b1});
      else if (lo == 16'd0)
         exp_q.push_back({2'b10, hi, 1'b1});
      else if (allow && (v % 32'd4 == 0) && s >= -131072 && s <= 131071)
         exp_q.push_back({2'b11, 16'(s / 4), 1'b1});
      else begin
         exp_q.push_back({2'b10, hi, 1'b0});
         exp_q.push_back({2'b01, lo, 1'b1});
      end
   endfunction

   function automatic logic [31:0] gen_value();
      int t;
      case ($urandom_range(0, 4))
         0: begin t = int'($urandom_range(0, 65535)); return 32'(t - 32768); end
         1: return 32'($urandom_range(0, 65535));
         2: return $urandom << 16;
         3: begin t = int'($urandom_range(0, 65535)); return 32'((t - 32768) * 4); end
         default: return $urandom;
      endcase
   endfunction

   // ---------------- scoreboard / stability monitor on instance a ----------------
   logic [19:0] held;
   bit          hold_pend = 0;

   always @(negedge clk) begin
      logic [19:0] cur;
      cur = {a.out_valid, a.out_eop, a.out_imm, a.out_last};
      if (reset) begin
         exp_q.delete();
         hold_pend = 0;
      end else begin
         if (hold_pend) check("hold_stable", {12'h0, cur}, {12'h0, held});
         if (a.out_valid && a.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", {31'h0, a.out_valid}, 32'h0);
            else check("sb_beat", {13'h0, cur[18:0]}, {13'h0, exp_q.pop_front()});
         end
         hold_pend = a.out_valid && !a.out_ready;
         held      = cur;
         if (a.in_valid && a.in_ready) model_push(a.in_value, 1'b1);
      end
   end

   // ---------------- stimulus ----------------
   bit acc;

   initial begin
      reset = 1'b1;
      a.in_valid = 1'b0; a.in_value = '0; a.out_ready = 1'b0;
      b.in_valid = 1'b0; b.in_value = '0; b.out_ready = 1'b1;

      // reset values
      step(); step();
      smp();
      check("rst_out_valid", {31'h0, a.out_valid}, 32'h0);
      check("rst_out_imm",   {16'h0, a.out_imm},   32'h0);
      check("rst_out_eop",   {30'h0, a.out_eop},   32'h0);
      check("rst_out_last",  {31'h0, a.out_last},  32'h0);
      check("rst_in_ready",  {31'h0, a.in_ready},  32'h0);
`ifdef IMM_PACK_STATS_EN
      check("rst_stat_single", stat_single_a, 32'h0);
      check("rst_stat_split",  stat_split_a,  32'h0);
`endif
      step(); reset = 1'b0;
      smp();
      check("in_ready_after_rst", {31'h0, a.in_ready}, 32'h1);

      // 0xFFFF8000 -> sign, one beat, latency 1
      step(); a.in_valid = 1'b1; a.in_value = 32'hFFFF8000; a.out_ready = 1'b1;
      smp();  check("c28_in_ready", {31'h0, a.in_ready}, 32'h1);
      step(); a.in_valid = 1'b0;
      smp();  check_out("c28_beat", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b00, 16'h8000, 1'b1);

      // back-to-back zero-extend then lui
      step(); a.in_valid = 1'b1; a.in_value = 32'h0000ABCD;
      smp();  check("c29_rdy0", {31'h0, a.in_ready}, 32'h1);
      step(); a.in_value = 32'h12340000;
      smp();  check_out("c29_beat0", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b01, 16'hABCD, 1'b1);
      check("c29_rdy1", {31'h0, a.in_ready}, 32'h1);
      step(); a.in_valid = 1'b0;
      smp();  check_out("c29_beat1", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b10, 16'h1234, 1'b1);
      step();
      smp();  check("c29_drained", {31'h0, a.out_valid}, 32'h0);

      // 0xFFFE0004: shift2 on a, split on b
      step(); a.in_valid = 1'b1; a.in_value = 32'hFFFE0004;
              b.in_valid = 1'b1; b.in_value = 32'hFFFE0004;
      smp();  check("c30_rdy_a", {31'h0, a.in_ready}, 32'h1);
      check("c30_rdy_b", {31'h0, b.in_ready}, 32'h1);
      step(); a.in_valid = 1'b0; b.in_valid = 1'b0;
      smp();  check_out("c30_a_sh2", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b11, 16'h8001, 1'b1);
      check_out("c30_b_hi", {b.out_valid, b.out_eop, b.out_imm, b.out_last}, 2'b10, 16'hFFFE, 1'b0);
      check("c30_b_rdy_hi", {31'h0, b.in_ready}, 32'h0);
      step();
      smp();  check_out("c30_b_lo", {b.out_valid, b.out_eop, b.out_imm, b.out_last}, 2'b01, 16'h0004, 1'b1);
      check("c30_a_drained", {31'h0, a.out_valid}, 32'h0);
      step();
      smp();  check("c30_b_drained", {31'h0, b.out_valid}, 32'h0);

      // 0x12345678 split, consumer stalls on the low beat
      step(); a.in_valid = 1'b1; a.in_value = 32'h12345678;
      smp();  check("c31_rdy", {31'h0, a.in_ready}, 32'h1);
      step(); a.in_valid = 1'b0;
      smp();  check_out("c31_hi", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b10, 16'h1234, 1'b0);
      check("c31_rdy_hi", {31'h0, a.in_ready}, 32'h0);
      step(); a.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp();
         check_out("c31_lo_held", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b01, 16'h5678, 1'b1);
         check("c31_rdy_stall", {31'h0, a.in_ready}, 32'h0);
         step();
      end
      a.out_ready = 1'b1;
      smp();  check_out("c31_lo_take", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b01, 16'h5678, 1'b1);
      check("c31_rdy_take", {31'h0, a.in_ready}, 32'h1);
      step();
      smp();  check("c31_drained", {31'h0, a.out_valid}, 32'h0);
`ifdef IMM_PACK_STATS_EN
      check("stat_single", stat_single_a, 32'd4);
      check("stat_split",  stat_split_a,  32'd1);
`endif

      // reset while holding the upper beat: low half must never appear
      step(); a.in_valid = 1'b1; a.in_value = 32'h12345678; a.out_ready = 1'b0;
      smp();
      step(); a.in_valid = 1'b0;
      smp();  check_out("c32_hi", {a.out_valid, a.out_eop, a.out_imm, a.out_last}, 2'b10, 16'h1234, 1'b0);
      step(); reset = 1'b1; a.out_ready = 1'b1;
      smp();
      step(); reset = 1'b0;
      smp();  check("c32_valid_after_rst", {31'h0, a.out_valid}, 32'h0);
      check("c32_rdy_after_rst", {31'h0, a.in_ready}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         step();
         smp();
         check("c32_no_lo_beat", {31'h0, a.out_valid}, 32'h0);
      end

      // randomized traffic with random consumer stalls
      acc = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!a.in_valid || acc) begin
            a.in_valid = ($urandom_range(0, 3) != 0);
            a.in_value = gen_value();
         end
         a.out_ready = ($urandom_range(0, 3) != 0);
         smp();
         acc = a.in_valid && a.in_ready;
      end
      step(); a.in_valid = 1'b0; a.out_ready = 1'b1;
      for (int k = 0; k < 50; k++) begin
         smp();
         if (exp_q.size() == 0 && !a.out_valid) break;
         step();
      end
      check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imm_pack.md
IMM_PACK -- requirements
Module: imm_pack

Interface
REQ-001 SHALL have parameter ALLOW_SHIFT2, default 1, meaning the shifted-by-2 sign-extend encoding (eop 2'b11) is a legal single-beat candidate.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, in_value holds a constant to pack.
REQ-005 SHALL have port in_ready, output, 1, block accepts in_value this cycle.
REQ-006 SHALL have port in_value, input, 32, constant to pack.
REQ-007 SHALL have port out_valid, output, 1, out_imm/out_eop/out_last hold a beat.
REQ-008 SHALL have port out_ready, input, 1, consumer takes the beat this cycle.
REQ-009 SHALL have port out_imm, output, 16, immediate field for the extender.
REQ-010 SHALL have port out_eop, output, 2, extender op: 00 sign, 01 zero, 10 upper (lui), 11 sign-shift-2.
REQ-011 SHALL have port out_last, output, 1, final beat of the current constant.

Function
REQ-012 SHALL accept input on in_valid && in_ready; each handshake is one transfer.
REQ-013 SHALL classify in priority: value[31:15] all equal -> eop 00, imm value[15:0]; else value[31:16]==0 -> eop 01, imm value[15:0]; else value[15:0]==0 -> eop 10, imm value[31:16]; else ALLOW_SHIFT2 && value[1:0]==0 && value[31:17] all equal -> eop 11, imm value[17:2].
REQ-014 SHALL emit any classified constant as one beat with out_last=1.
REQ-015 SHALL emit an unclassifiable constant as two beats: {eop 10, imm value[31:16], last 0} then {eop 01, imm value[15:0], last 1}.
REQ-016 SHALL use FSM states IDLE (output empty), ONE (single/low beat held), HI (upper beat held, low half stored); IDLE/ONE --accept, split--> HI; IDLE/ONE --accept, fits--> ONE; HI --out_ready--> ONE (low beat); ONE --out_ready, no accept--> IDLE.
REQ-017 SHALL present out_valid exactly one cycle after acceptance (registered output, latency 1).
REQ-018 SHALL drive in_ready = (state==IDLE) || (state==ONE && out_ready); in_ready low in HI.
REQ-019 SHALL hold out_imm, out_eop, out_last stable while out_valid && !out_ready.
REQ-020 SHALL, on a ONE-state drain coincident with acceptance, load the new beat with no bubble.
REQ-021 SHALL sustain one constant per cycle for single-beat traffic with out_ready held high.

Reset
REQ-022 SHALL, while reset is high at a clk edge, enter IDLE and drive out_valid=0, out_imm=0, out_eop=00, out_last=0, in_ready=0; in_ready=1 the cycle after reset deasserts.
REQ-023 SHALL discard any in-flight split constant (including the stored low half) on reset in HI.

Configuration
REQ-024 SHALL, with macro IMM_PACK_STATS_EN defined, add output ports stat_single[31:0] and stat_split[31:0], counting accepted single-beat and split constants, reset to 0, wrapping at 2^32.
REQ-025 SHALL, without IMM_PACK_STATS_EN, omit those ports and counters entirely; packing behaviour identical.

Structure
REQ-026 SHALL place eop encodings (EOP_SIGN, EOP_ZERO, EOP_UPPER, EOP_SIGN_SH2) and FSM state typedef in shared package imm_pkg, also used by the extender.
REQ-027 SHALL factor REQ-013 into combinational sub-module imm_classify (inputs value, allow_sh2; outputs fits, eop, imm).

Verification
REQ-028 SHALL cover 0xFFFF8000 -> one beat eop 00, imm 0x8000, last 1.
REQ-029 SHALL cover 0x0000ABCD then 0x12340000 back-to-back, out_ready high -> beats {01,0xABCD,1},{10,0x1234,1} on consecutive cycles, in_ready held high.
REQ-030 SHALL cover 0xFFFE0004 -> {11,0x8001,1} with ALLOW_SHIFT2=1; with ALLOW_SHIFT2=0 -> {10,0xFFFE,0},{01,0x0004,1}.
REQ-031 SHALL cover 0x12345678, out_ready low 3 cycles on the second beat -> {10,0x1234,0} then {01,0x5678,1} held stable, in_ready low in HI.
REQ-032 SHALL cover reset asserted in HI after 0x12345678 -> out_valid 0 next cycle, no low beat ever emitted.
REQ-033 SHALL cover, with IMM_PACK_STATS_EN, REQ-028..REQ-031 sequence -> stat_single=4, stat_split=1 (ALLOW_SHIFT2=1 run).
